chunked_addsub: RTL
===================

Name: chunked_addsub

Overview:
- Parametrised multi-cycle adder/subtractor and sequential successor of the team's combinational 4-bit adder (`out` = a+b, WIDTH+1 bits).
- Processes WIDTH-bit operands CHUNK bits per clock, LSB chunk first, through a narrow carry chain. This trades latency for area and timing.
- Adds a subtract mode, signed-overflow flag and a valid/ready handshake.
- Sits between an operand source and a result consumer in lab datapaths; replaces the combinational adder where a wide carry chain misses timing.

Parameters:
- WIDTH, 8, operand width in bits; must be ≥ 1.
- CHUNK, 2, bits processed per clock; 1 ≤ CHUNK ≤ WIDTH and WIDTH % CHUNK == 0. Elaboration error otherwise.
- NCHUNK (localparam), WIDTH/CHUNK, number of RUN cycles per operation.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and mode are valid.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- sub  in  1  0: a+b; 1: a−b. Sampled only at accept.
- out_valid  out  1  one-cycle pulse: result valid.
- out  out  WIDTH+1  result; bit WIDTH is carry (add) or borrow (sub).
- ovf  out  1  signed two's-complement overflow of out[WIDTH-1:0].

Behaviour:
- Reset (async assert, any state, including mid-RUN):
  - state=IDLE; in_ready=1; out_valid=0; out=0; ovf=0; internal registers cleared.
  - Any in-flight operation is discarded; no out_valid for it.
- States: IDLE, RUN, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
- IDLE:
  - Accept when in_valid && in_ready on a rising edge.
  - Latch a into opA and (sub ? ~b : b) into opB; carry=sub; save msbA=a[WIDTH-1], msbB=b[WIDTH-1] and sub.
  - cnt=0; go to RUN.
- RUN, each edge:
  - Feed opA[CHUNK-1:0], opB[CHUNK-1:0] and carry through the chunk adder.
  - Shift the CHUNK-bit sum into the top of the sum shift register, shifting it right by CHUNK.
  - Shift opA and opB right by CHUNK; carry=chunk carry-out; cnt++.
  - On the edge processing cnt==NCHUNK-1:
    - Load out[WIDTH-1:0] with the final sum.
    - out[WIDTH] = sub ? ~carry_final : carry_final.
    - ovf = (msbA == (sub ? ~msbB : msbB)) && (sum[WIDTH-1] != msbA).
    - Go to DONE.
- DONE: out_valid=1 for exactly one cycle; next edge goes to IDLE.
- out and ovf hold their values until the next completion or reset.
- Latency: out_valid is high in the cycle beginning NCHUNK clock edges after the accept edge. in_ready returns after NCHUNK+1 edges. Throughput is one op per NCHUNK+2 cycles.
- in_valid during RUN or DONE is ignored; the source must hold it until accepted.
- CHUNK==WIDTH gives a single RUN cycle.
- Arithmetic is modulo 2^WIDTH in out[WIDTH-1:0]. In sub mode, borrow=1 iff a<b unsigned.

Decomposition:
- Shared package/include `addsub_defs`: state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the chunk-divisibility check macro.
- One sub-module, `chunk_add`: CHUNK-bit ripple adder with ports x, y, cin, s, cout. Instantiated once; the FSM and shift registers live in the top.

Test Plan:
- WIDTH=4, CHUNK=1, add a=11, b=13 → out=5'd24 (11000), ovf=0; out_valid exactly 4 cycles after the accept edge, high for 1 cycle.
- WIDTH=4, CHUNK=1, add a=7, b=6 → out=5'd13, ovf=1. Add a=15, b=12 → out=5'd27, ovf=0.
- WIDTH=4, CHUNK=1, sub a=5, b=2 → out=5'b00011, ovf=0. Sub a=0, b=3 → out=5'b11101 (borrow=1), ovf=0.
- Default WIDTH=8, CHUNK=2, add a=200, b=100 → out=9'd300, ovf=0, latency 4. With CHUNK=8 the same op completes with latency 1.
- Hold in_valid high with changing a/b during RUN → only the first op is accepted; the next accept occurs in the first IDLE cycle, and its result matches its own operands.
- Assert rst on the 2nd RUN cycle → out=0, out_valid=0, in_ready=1 immediately and no spurious pulse. After release, 9+9 (WIDTH=4) → out=5'd18, ovf=1.

Source files
------------

// File: rtl/addsub_defs.sv
// Shared definitions for the chunked adder/subtractor.
// Contents:
//   state_t       - controller state encoding (IDLE / RUN / DONE)
//   chunk_cfg_ok  - elaboration-time check of the WIDTH/CHUNK pairing
//   cnt_bits      - width of the chunk counter for a given chunk count
package addsub_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The operand must split into a whole number of non-empty chunks.
  function automatic bit chunk_cfg_ok(input int width, input int chunk);
    return (width >= 1) && (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

  // The counter needs at least one bit, even when a single chunk covers the word.
  function automatic int cnt_bits(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/chunked_addsub_chunk_add.sv
// chunk_add: CHUNK-bit ripple-carry adder slice.
// Ports:
//   x, y  in  CHUNK  addend bits of the current chunk
//   cin   in  1      carry from the previous (less significant) chunk
//   s     out CHUNK  chunk sum
//   cout  out 1      carry into the next chunk
module chunk_add #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  // One full adder per bit; carries ripple from bit 0 upward.
  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign cout = c[CHUNK];

endmodule

// File: rtl/chunked_addsub.sv
// chunked_addsub: multi-cycle adder/subtractor that walks WIDTH-bit operands
// through a CHUNK-bit carry chain, least significant chunk first.
// Ports:
//   clk        in   1        rising-edge clock
//   rst        in   1        asynchronous active-high reset
//   in_valid   in   1        operands and mode are valid
//   in_ready   out  1        high only while idle; accept = in_valid & in_ready
//   a, b       in   WIDTH    operands (unsigned or two's complement)
//   sub        in   1        0: a+b, 1: a-b (sampled at accept)
//   out_valid  out  1        one-cycle result pulse
//   out        out  WIDTH+1  result; top bit is carry (add) or borrow (sub)
//   ovf        out  1        signed overflow of out[WIDTH-1:0]
module chunked_addsub
  import addsub_defs::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  output logic [WIDTH:0]   out,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = cnt_bits(NCHUNK);

  if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
    $error("chunked_addsub: CHUNK must divide WIDTH and satisfy 1 <= CHUNK <= WIDTH");
  end

  state_t                 state;
  state_t                 next_state;
  logic [WIDTH-1:0]       op_a;
  logic [WIDTH-1:0]       op_b;
  logic                   carry;
  logic                   msb_a;
  logic                   msb_b;
  logic                   sub_mode;
  logic [CW-1:0]          cnt;
  logic [WIDTH-1:0]       sum_sr;
  logic [CHUNK-1:0]       chunk_sum;
  logic                   chunk_cout;
  logic [WIDTH+CHUNK-1:0] sum_cat;
  logic [WIDTH-1:0]       sum_next;
  logic                   accept;
  logic                   last;

  chunk_add #(
    .CHUNK (CHUNK)
  ) u_chunk_add (
    .x    (op_a[CHUNK-1:0]),
    .y    (op_b[CHUNK-1:0]),
    .cin  (carry),
    .s    (chunk_sum),
    .cout (chunk_cout)
  );

  // New chunk enters at the top; the register shifts right by CHUNK. The
  // concatenation form also covers CHUNK == WIDTH, where nothing survives.
  assign sum_cat  = {chunk_sum, sum_sr};
  assign sum_next = sum_cat[WIDTH+CHUNK-1:CHUNK];

  assign accept = in_valid && (state == IDLE);
  assign last   = (cnt == CW'(NCHUNK - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = RUN;
        end else begin
          next_state = IDLE;
        end
      end
      RUN: begin
        if (last) begin
          next_state = DONE;
        end else begin
          next_state = RUN;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Operand latch, chunk-serial datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a     <= '0;
      op_b     <= '0;
      carry    <= 1'b0;
      msb_a    <= 1'b0;
      msb_b    <= 1'b0;
      sub_mode <= 1'b0;
      cnt      <= '0;
      sum_sr   <= '0;
      out      <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
            op_a     <= a;
            op_b     <= sub ? ~b : b;
            carry    <= sub;
            msb_a    <= a[WIDTH-1];
            msb_b    <= b[WIDTH-1];
            sub_mode <= sub;
            cnt      <= '0;
            sum_sr   <= '0;
          end
        end
        RUN: begin
          op_a   <= op_a >> CHUNK;
          op_b   <= op_b >> CHUNK;
          carry  <= chunk_cout;
          sum_sr <= sum_next;
          cnt    <= cnt + CW'(1);
          if (last) begin
            // In subtract mode a carry-out of 1 means no borrow.
            out <= {(sub_mode ? ~chunk_cout : chunk_cout), sum_next};
            // Overflow: effective operand signs agree but the result sign differs.
            ovf <= (msb_a == (sub_mode ? ~msb_b : msb_b)) && (sum_next[WIDTH-1] != msb_a);
          end
        end
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end

endmodule
